// File: rtl/regfile_wr_arbiter.sv
// Single write port of the register file: zero-clears every register after reset,
// then round-robin arbitrates two valid/ready requesters. Optional: REGFILE_ARB_R0_PROTECT_EN.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rr_ptr;

  logic              gnt0;
  logic              gnt1;
  logic              both_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_ok;

  // Grant: a lone requester always wins; on contention rr_ptr picks (0 -> req0).
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    both_valid = req0_valid && req1_valid;
    if (state == ARB) begin
      if (both_valid) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    if (gnt1) begin
      win_addr = req1_addr;
      win_data = req1_data;
    end
  end

`ifdef REGFILE_ARB_R0_PROTECT_EN
  // Register 0 is hardwired zero: accepted writes to it are dropped.
  assign wr_ok = (win_addr != '0);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      rr_ptr    <= 1'b0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rf_wen   <= 1'b1;
          rf_waddr <= cnt;
          rf_wdata <= '0;
          cnt      <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) begin
            state     <= ARB;
            init_done <= 1'b1;
          end
        end
        ARB: begin
          if (gnt0 || gnt1) begin
            rf_wen <= wr_ok;
            if (wr_ok) begin
              rf_waddr <= win_addr;
              rf_wdata <= win_data;
            end
            // Fairness only shifts when the loser actually had to wait.
            if (both_valid) begin
              rr_ptr <= ~rr_ptr;
            end
          end else begin
            rf_wen <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a cycle-level reference model
// and a shadow register file built from the write port.
module tb_regfile_wr_arbiter;

  localparam int NUM_REGS = 16;
`ifdef REGFILE_ARB_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [3:0]  req0_addr = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [3:0]  req1_addr = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        init_done;

  regfile_wr_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_live = 1'b0;
  int          m_cnt  = 0;
  int          m_fav  = 0;
  logic        e_wen = 1'b0, e_done = 1'b0;
  logic [3:0]  e_waddr = '0;
  logic [15:0] e_wdata = '0;
  logic        e_r0 = 1'b0, e_r1 = 1'b0;
  logic [15:0] m_rf [NUM_REGS];
  logic [15:0] dut_rf [NUM_REGS];

  // Requester bookkeeping
  bit          acc0 = 1'b0, acc1 = 1'b0;
  bit          nx0 = 1'b0;
  logic [3:0]  nx0_a = '0;
  logic [15:0] nx0_d = '0;

  // Shadow register file fed only by the DUT write port
  always @(posedge clk) begin
    if (rf_wen === 1'b1) dut_rf[rf_waddr] <= rf_wdata;
  end

  // Requesters must hold valid/addr/data until accepted
  logic        p_v0 = 1'b0, p_r0 = 1'b0, p_v1 = 1'b0, p_r1 = 1'b0;
  logic [3:0]  p_a0 = '0, p_a1 = '0;
  logic [15:0] p_d0 = '0, p_d1 = '0;
  always @(posedge clk) begin
    if (p_v0 && !p_r0)
      assert (req0_valid && req0_addr == p_a0 && req0_data == p_d0)
        else $error("req0 retracted before acceptance");
    if (p_v1 && !p_r1)
      assert (req1_valid && req1_addr == p_a1 && req1_data == p_d1)
        else $error("req1 retracted before acceptance");
    p_v0 <= req0_valid; p_r0 <= e_r0 && rst_n; p_a0 <= req0_addr; p_d0 <= req0_data;
    p_v1 <= req1_valid; p_r1 <= e_r1 && rst_n; p_a1 <= req1_addr; p_d1 <= req1_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected effect of the coming clock edge, from the behavioural rules
  task automatic model_edge();
    int          win;
    logic [3:0]  a;
    logic [15:0] d;
    if (!rst_n) begin
      m_live = 1'b1; m_cnt = 0; m_fav = 0;
      e_wen = 1'b0; e_waddr = '0; e_wdata = '0; e_done = 1'b0;
    end else if (m_live && m_cnt < NUM_REGS) begin
      e_wen = 1'b1; e_waddr = 4'(m_cnt); e_wdata = '0;
      m_rf[m_cnt] = '0;
      m_cnt++;
      e_done = (m_cnt == NUM_REGS);
    end else if (e_r0 || e_r1) begin
      win = e_r1 ? 1 : 0;
      a   = e_r1 ? req1_addr : req0_addr;
      d   = e_r1 ? req1_data : req0_data;
      if (PROT && a == 4'd0) begin
        e_wen = 1'b0;
      end else begin
        e_wen = 1'b1; e_waddr = a; e_wdata = d;
        m_rf[a] = d;
      end
      if (req0_valid && req1_valid) m_fav = 1 - win;
    end else begin
      e_wen = 1'b0;
    end
  endtask

  task automatic cycle(input logic rst, input int pct0, input int pct1, input bit fixed);
    bit in_arb;
    @(negedge clk);
    rst_n = rst;
    if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
    if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
    if (!req0_valid && nx0) begin
      req0_valid = 1'b1; req0_addr = nx0_a; req0_data = nx0_d; nx0 = 1'b0;
    end
    if (!req0_valid && int'($urandom_range(99)) < pct0) begin
      req0_valid = 1'b1;
      req0_addr  = fixed ? 4'd1 : 4'($urandom_range(15));
      req0_data  = fixed ? 16'hAAAA : 16'($urandom);
    end
    if (!req1_valid && int'($urandom_range(99)) < pct1) begin
      req1_valid = 1'b1;
      req1_addr  = fixed ? 4'd2 : 4'($urandom_range(15));
      req1_data  = fixed ? 16'h5555 : 16'($urandom);
    end
    #1;
    in_arb = m_live && (m_cnt >= NUM_REGS);
    e_r0 = in_arb && req0_valid && (!req1_valid || m_fav == 0);
    e_r1 = in_arb && req1_valid && (!req0_valid || m_fav == 1);
    if (m_live) begin
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      chk("rf_wen", 32'(rf_wen), 32'(e_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
      chk("rf_wdata", 32'(rf_wdata), 32'(e_wdata));
      chk("init_done", 32'(init_done), 32'(e_done));
    end
    model_edge();
    acc0 = e_r0 && rst;
    acc1 = e_r1 && rst;
  endtask

  initial begin
    repeat (2) cycle(1'b0, 0, 0, 1'b0);
    // req0 waits through the whole clear sequence
    nx0 = 1'b1; nx0_a = 4'd3; nx0_d = 16'hBEEF;
    repeat (18) cycle(1'b1, 0, 0, 1'b0);
    // contention with fixed payloads: grants alternate
    repeat (12) cycle(1'b1, 100, 100, 1'b1);
    repeat (3) cycle(1'b1, 0, 0, 1'b0);
    // one-cycle reset mid-arbitration restarts the clear
    cycle(1'b0, 0, 0, 1'b0);
    repeat (17) cycle(1'b1, 0, 0, 1'b0);
    // req1 alone, then contention: req0 must be first
    repeat (4) cycle(1'b1, 0, 100, 1'b0);
    repeat (6) cycle(1'b1, 100, 100, 1'b0);
    repeat (2) cycle(1'b1, 0, 0, 1'b0);
    // write to register 0
    nx0 = 1'b1; nx0_a = 4'd0; nx0_d = 16'hFFFF;
    repeat (3) cycle(1'b1, 0, 0, 1'b0);
    // random traffic with rare resets
    repeat (600) cycle(logic'($urandom_range(99) != 0), 60, 60, 1'b0);
    repeat (24) cycle(1'b1, 0, 0, 1'b0);
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("rf[%0d]", i), 32'(dut_rf[i]), 32'(m_rf[i]));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
